// File: rtl/significand_mul_seq_if.sv
// Operand/result handshake bundle for the sequential significand multiplier.
// The master side supplies operands and consumes results; the slave side is
// the multiplier itself.
interface significand_mul_seq_if #(
  parameter int MW = 23
);
  localparam int SW = $clog2(2 * (MW + 1));

  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] Mx;
  logic [MW-1:0] My;
  logic          zero_Ex;
  logic          zero_Ey;
  logic [1:0]    R_mode;
  logic          Sz;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] Mz;
  logic          ovf;
  logic [SW-1:0] SHL;
  logic          Overflow_after_round;
  logic          zero_out;

  modport master (
    output in_valid, Mx, My, zero_Ex, zero_Ey, R_mode, Sz, out_ready,
    input  in_ready, out_valid, Mz, ovf, SHL, Overflow_after_round, zero_out
  );

  modport slave (
    input  in_valid, Mx, My, zero_Ex, zero_Ey, R_mode, Sz, out_ready,
    output in_ready, out_valid, Mz, ovf, SHL, Overflow_after_round, zero_out
  );
endinterface

// File: rtl/significand_mul_seq.sv
// Multi-cycle significand multiplier: shift-add product of the two W-bit
// significands (BPC multiplier bits per cycle, MSB first), then one cycle of
// normalisation and one cycle of IEEE-754 rounding. Results are held until the
// consumer takes them; exponent adjustment happens downstream.
module significand_mul_seq #(
  parameter int MW  = 23,
  parameter int BPC = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  significand_mul_seq_if.slave bus
);
  localparam int W     = MW + 1;
  localparam int SW    = $clog2(2 * W);
  localparam int STEPS = W / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_RND,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // operand / product path
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [1:0]      rmode_q, rmode_d;
  logic            sz_q, sz_d;

  // normalised value waiting for rounding
  logic [MW-1:0]   frac_q, frac_d;
  logic            g_q, g_d;
  logic            s_q, s_d;
  logic            ovfn_q, ovfn_d;
  logic [SW-1:0]   shln_q, shln_d;
  logic            zn_q, zn_d;

  // registered results
  logic [MW-1:0]   mz_q, mz_d;
  logic            ovf_q, ovf_d;
  logic [SW-1:0]   shl_q, shl_d;
  logic            oar_q, oar_d;
  logic            zero_q, zero_d;

  logic [2*W-1:0]  pp;
  logic [SW-1:0]   lz;
  logic [2*W-3:0]  p_sh;

  // Round-up decision: one ulp added when the discarded part demands it.
  function automatic logic round_inc(input logic [1:0] mode, input logic sz,
                                     input logic g, input logic s, input logic lsb);
    logic inc;
    case (mode)
      2'b00:   inc = g & (s | lsb);
      2'b01:   inc = 1'b0;
      2'b10:   inc = ~sz & (g | s);
      default: inc = sz & (g | s);
    endcase
    return inc;
  endfunction

  assign bus.in_ready             = (state_q == S_IDLE);
  assign bus.out_valid            = (state_q == S_DONE);
  assign bus.Mz                   = mz_q;
  assign bus.ovf                  = ovf_q;
  assign bus.SHL                  = shl_q;
  assign bus.Overflow_after_round = oar_q;
  assign bus.zero_out             = zero_q;

  // Partial product of the multiplicand with the top BPC multiplier bits,
  // and the leading-zero count used for subnormal products.
  always_comb begin
    pp = (2*W)'(x_q) * (2*W)'(y_q[W-1 -: BPC]);
    lz = '0;
    for (int i = 0; i < 2*W-1; i++) begin
      if (acc_q[i]) lz = SW'(2*W - 2 - i);
    end
    p_sh = acc_q[2*W-3:0] << lz;
  end

  // Next-state and datapath updates for the accept/multiply/normalise/round sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    rmode_d = rmode_q;
    sz_d    = sz_q;
    frac_d  = frac_q;
    g_d     = g_q;
    s_d     = s_q;
    ovfn_d  = ovfn_q;
    shln_d  = shln_q;
    zn_d    = zn_q;
    mz_d    = mz_q;
    ovf_d   = ovf_q;
    shl_d   = shl_q;
    oar_d   = oar_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d     = {~bus.zero_Ex, bus.Mx};
          y_d     = {~bus.zero_Ey, bus.My};
          acc_d   = '0;
          cnt_d   = '0;
          rmode_d = bus.R_mode;
          sz_d    = bus.Sz;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // MSB-first: earlier digits get shifted up as later ones are added
        acc_d = (acc_q << BPC) + pp;
        y_d   = y_q << BPC;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (acc_q == '0) begin
          frac_d = '0;
          g_d    = 1'b0;
          s_d    = 1'b0;
          ovfn_d = 1'b0;
          shln_d = '0;
          zn_d   = 1'b1;
        end else if (acc_q[2*W-1]) begin
          frac_d = acc_q[2*W-2 -: MW];
          g_d    = acc_q[MW];
          s_d    = |acc_q[MW-1:0];
          ovfn_d = 1'b1;
          shln_d = '0;
          zn_d   = 1'b0;
        end else begin
          // lz is zero when the leading one already sits in the [1,2) position
          frac_d = p_sh[2*W-3 -: MW];
          g_d    = p_sh[MW-1];
          s_d    = |p_sh[MW-2:0];
          ovfn_d = 1'b0;
          shln_d = lz;
          zn_d   = 1'b0;
        end
        state_d = S_RND;
      end
      S_RND: begin
        {oar_d, mz_d} = {1'b0, frac_q}
                      + {{MW{1'b0}}, round_inc(rmode_q, sz_q, g_q, s_q, frac_q[0])};
        ovf_d   = ovfn_q;
        shl_d   = shln_q;
        zero_d  = zn_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and visible results; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mz_q    <= '0;
      ovf_q   <= 1'b0;
      shl_q   <= '0;
      oar_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mz_q    <= mz_d;
      ovf_q   <= ovf_d;
      shl_q   <= shl_d;
      oar_q   <= oar_d;
      zero_q  <= zero_d;
    end
  end

  // Internal datapath registers need no reset: each is loaded before it is read.
  always_ff @(posedge clk) begin
    x_q     <= x_d;
    y_q     <= y_d;
    acc_q   <= acc_d;
    rmode_q <= rmode_d;
    sz_q    <= sz_d;
    frac_q  <= frac_d;
    g_q     <= g_d;
    s_q     <= s_d;
    ovfn_q  <= ovfn_d;
    shln_q  <= shln_d;
    zn_q    <= zn_d;
  end
endmodule

// File: tb/tb_significand_mul_seq.sv
// Self-checking bench for significand_mul_seq (MW=23, BPC=2): directed vector
// table, stall and mid-operation reset sequences, and a random sweep against
// an arithmetic reference model.
module tb_significand_mul_seq;
  localparam int MW  = 23;
  localparam int BPC = 2;
  localparam int LAT = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  significand_mul_seq_if #(.MW(MW)) bus ();

  significand_mul_seq #(.MW(MW), .BPC(BPC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [22:0] mz;
    logic        ovf;
    logic [5:0]  shl;
    logic        oar;
    logic        zero;
  } res_t;

  typedef struct packed {
    logic [22:0] mx;
    logic [22:0] my;
    logic        zx;
    logic        zy;
    logic [1:0]  rm;
    logic        sz;
    res_t        exp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [22:0] mx, input logic [22:0] my, input logic zx,
                         input logic zy, input logic [1:0] rm, input logic sz,
                         input logic [22:0] mz, input logic ovf, input logic [5:0] shl,
                         input logic oar, input logic zero);
    vec_t v;
    v.mx = mx; v.my = my; v.zx = zx; v.zy = zy; v.rm = rm; v.sz = sz;
    v.exp.mz = mz; v.exp.ovf = ovf; v.exp.shl = shl; v.exp.oar = oar; v.exp.zero = zero;
    tbl.push_back(v);
  endtask

  // Reference: exact integer product, scaled into [1,4), rounded by remainder comparison.
  function automatic res_t model(input logic [22:0] mx, input logic [22:0] my, input logic zx,
                                 input logic zy, input logic [1:0] rm, input logic sz);
    res_t r;
    longint unsigned x, y, p, q, rem, half;
    int k;
    int shl;
    bit inc;
    r = '0;
    x = (zx ? 0 : 64'd1 << 23) + longint'(mx);
    y = (zy ? 0 : 64'd1 << 23) + longint'(my);
    p = x * y;
    if (p == 0) begin
      r.zero = 1'b1;
      return r;
    end
    shl = 0;
    while (p < (64'd1 << 46)) begin
      p = p * 2;
      shl++;
    end
    r.shl = 6'(shl);
    if (p >= (64'd1 << 47)) begin
      r.ovf = 1'b1;
      k = 24;
    end else begin
      k = 23;
    end
    q    = p >> k;
    rem  = p - (q << k);
    half = 64'd1 << (k - 1);
    case (rm)
      2'd0:    inc = (rem > half) || (rem == half && (q % 2) == 1);
      2'd1:    inc = 1'b0;
      2'd2:    inc = !sz && rem != 0;
      default: inc = sz && rem != 0;
    endcase
    q = q + (inc ? 1 : 0);
    r.oar = (q == (64'd1 << 24));
    r.mz  = 23'(q % (64'd1 << 23));
    return r;
  endfunction

  // One full transaction: accept, wait for the result (bounded), sample, hand it off.
  task automatic run_op(input logic [22:0] mx, input logic [22:0] my, input logic zx,
                        input logic zy, input logic [1:0] rm, input logic sz,
                        output res_t r, output int lat);
    @(negedge clk);
    bus.Mx = mx; bus.My = my; bus.zero_Ex = zx; bus.zero_Ey = zy;
    bus.R_mode = rm; bus.Sz = sz; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    r.mz = bus.Mz; r.ovf = bus.ovf; r.shl = bus.SHL;
    r.oar = bus.Overflow_after_round; r.zero = bus.zero_out;
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic check_res(input string tag, input res_t got, input res_t exp);
    chk({tag, ".Mz"},   longint'(got.mz),   longint'(exp.mz));
    chk({tag, ".ovf"},  longint'(got.ovf),  longint'(exp.ovf));
    chk({tag, ".SHL"},  longint'(got.shl),  longint'(exp.shl));
    chk({tag, ".oar"},  longint'(got.oar),  longint'(exp.oar));
    chk({tag, ".zero"}, longint'(got.zero), longint'(exp.zero));
  endtask

  initial begin
    res_t r;
    int   lat;
    bit   seen;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.Mx = '0; bus.My = '0;
    bus.zero_Ex = 1'b0; bus.zero_Ey = 1'b0; bus.R_mode = 2'd0; bus.Sz = 1'b0;

    // mx, my, zx, zy, rm, sz | Mz, ovf, SHL, oar, zero
    add_vec(23'h000000, 23'h000000, 0, 0, 2'd0, 0, 23'h000000, 0, 6'd0, 0, 0);
    add_vec(23'h400000, 23'h400000, 0, 0, 2'd0, 0, 23'h100000, 1, 6'd0, 0, 0);
    add_vec(23'h000001, 23'h400000, 0, 0, 2'd0, 0, 23'h400002, 0, 6'd0, 0, 0);
    add_vec(23'h000001, 23'h400000, 0, 0, 2'd1, 0, 23'h400001, 0, 6'd0, 0, 0);
    add_vec(23'h7FFFFF, 23'h000001, 0, 0, 2'd0, 0, 23'h000000, 1, 6'd0, 0, 0);
    add_vec(23'h7FFFFF, 23'h000001, 0, 0, 2'd1, 0, 23'h000000, 1, 6'd0, 0, 0);
    add_vec(23'h7FFFFF, 23'h000001, 0, 0, 2'd2, 0, 23'h000001, 1, 6'd0, 0, 0);
    add_vec(23'h7FFFFF, 23'h000001, 0, 0, 2'd2, 1, 23'h000000, 1, 6'd0, 0, 0);
    add_vec(23'h7FFFFF, 23'h000001, 0, 0, 2'd3, 1, 23'h000001, 1, 6'd0, 0, 0);
    add_vec(23'h000001, 23'h7FFFFE, 0, 0, 2'd0, 0, 23'h000000, 0, 6'd0, 1, 0);
    add_vec(23'h000001, 23'h7FFFFE, 0, 0, 2'd1, 0, 23'h7FFFFF, 0, 6'd0, 0, 0);
    add_vec(23'h000001, 23'h7FFFFE, 0, 0, 2'd3, 1, 23'h000000, 0, 6'd0, 1, 0);
    add_vec(23'h000001, 23'h7FFFFE, 0, 0, 2'd3, 0, 23'h7FFFFF, 0, 6'd0, 0, 0);
    add_vec(23'h200000, 23'h000000, 1, 0, 2'd0, 0, 23'h000000, 0, 6'd2, 0, 0);
    add_vec(23'h000000, 23'h123456, 1, 0, 2'd0, 0, 23'h000000, 0, 6'd0, 0, 1);
    add_vec(23'h400000, 23'h400000, 1, 1, 2'd0, 0, 23'h000000, 0, 6'd2, 0, 0);

    // reset state, sampled while reset is held
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready",  longint'(bus.in_ready),  1);
    chk("rst.out_valid", longint'(bus.out_valid), 0);
    chk("rst.Mz",        longint'(bus.Mz),        0);
    chk("rst.ovf",       longint'(bus.ovf),       0);
    chk("rst.SHL",       longint'(bus.SHL),       0);
    chk("rst.oar",       longint'(bus.Overflow_after_round), 0);
    chk("rst.zero",      longint'(bus.zero_out),  0);
    @(negedge clk) rst_n = 1'b1;

    // directed table
    foreach (tbl[i]) begin
      run_op(tbl[i].mx, tbl[i].my, tbl[i].zx, tbl[i].zy, tbl[i].rm, tbl[i].sz, r, lat);
      chk($sformatf("vec%0d.latency", i), longint'(lat), LAT);
      check_res($sformatf("vec%0d", i), r, tbl[i].exp);
    end

    // stall: result held 5 cycles with out_ready low, extra in_valid ignored
    @(negedge clk);
    bus.Mx = 23'h400000; bus.My = 23'h400000; bus.zero_Ex = 1'b0; bus.zero_Ey = 1'b0;
    bus.R_mode = 2'd0; bus.Sz = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("stall.latency", longint'(lat), LAT);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.Mx = 23'h7FFFFF; bus.My = 23'h7FFFFF; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d.out_valid", c), longint'(bus.out_valid), 1);
      chk($sformatf("stall%0d.in_ready", c),  longint'(bus.in_ready),  0);
      chk($sformatf("stall%0d.Mz", c),        longint'(bus.Mz),        23'h100000);
      chk($sformatf("stall%0d.ovf", c),       longint'(bus.ovf),       1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("stall.release.in_ready",  longint'(bus.in_ready),  1);
    chk("stall.release.out_valid", longint'(bus.out_valid), 0);
    seen = 1'b0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen = 1'b1;
    end
    chk("stall.no_ghost_result", longint'(seen), 0);

    // reset in the middle of the multiply phase
    @(negedge clk);
    bus.Mx = 23'h123456; bus.My = 23'h654321; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", longint'(bus.out_valid), 0);
    chk("midrst.in_ready",  longint'(bus.in_ready),  1);
    chk("midrst.Mz",        longint'(bus.Mz),        0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst.aborted", longint'(seen), 0);

    // random sweep over all rounding modes and both signs
    for (int i = 0; i < 48; i++) begin
      logic [22:0] mx, my;
      logic        zx, zy, sz;
      logic [1:0]  rm;
      mx = 23'($urandom);
      my = 23'($urandom);
      zx = ($urandom_range(0, 3) == 0);
      zy = ($urandom_range(0, 3) == 0);
      if (zx) mx = mx >> $urandom_range(0, 22);
      if (zy) my = my >> $urandom_range(0, 22);
      rm = 2'(i % 4);
      sz = 1'((i / 4) % 2);
      run_op(mx, my, zx, zy, rm, sz, r, lat);
      chk($sformatf("rnd%0d.latency", i), longint'(lat), LAT);
      check_res($sformatf("rnd%0d", i), r, model(mx, my, zx, zy, rm, sz));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
